muldiv_iter: RTL and testbench



---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 164 ++++++++++++++++
 tb/tb_muldiv_iter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and negation helper for the iterative
// MIPS multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   // Widest value neg_w can negate; limits the unit to WIDTH <= 64.
   localparam int unsigned MD_MAXW = 128;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Two's-complement negation modulo 2^w.
   function automatic logic [MD_MAXW-1:0] neg_w(input logic [MD_MAXW-1:0] x,
                                                input int unsigned       w);
      logic [MD_MAXW-1:0] mask;
      mask = (w >= MD_MAXW) ? '1 : ((MD_MAXW'(1) << w) - MD_MAXW'(1));
      return (~x + MD_MAXW'(1)) & mask;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per cycle through a
// single shared (WIDTH+1)-bit adder/subtractor, HI/LO held until next result.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             annul,
   output logic             stall_req,
   output logic             ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_opnd;
   logic [W2-1:0]    r_acc;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_ready;
   logic             r_div_zero;

   logic             w_is_div;
   logic             w_signed;
   logic             w_b_zero;
   logic             w_accept;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH:0]   w_add_a;
   logic [WIDTH:0]   w_add_b;
   logic [WIDTH:0]   w_sum;
   logic [W2-1:0]    w_step;
   logic [W2-1:0]    w_prod_fix;
   logic [WIDTH-1:0] w_quot_fix;
   logic [WIDTH-1:0] w_rem_fix;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   assign w_is_div = (op == MD_DIVU) || (op == MD_DIV);
   assign w_signed = (op == MD_MULT) || (op == MD_DIV);
   assign w_b_zero = (b == '0);
   assign w_accept = (r_state == IDLE) && start && !annul;

   assign w_abs_a = (w_signed && a[WIDTH-1]) ? WIDTH'(neg_w(MD_MAXW'(a), WIDTH)) : a;
   assign w_abs_b = (w_signed && b[WIDTH-1]) ? WIDTH'(neg_w(MD_MAXW'(b), WIDTH)) : b;

   // Multiply: acc = {partial product, multiplier}, shifted right each step.
   // Divide:   acc = {partial remainder, dividend/quotient}, shifted left.
   assign w_add_a = r_is_div ? {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]}
                             : {1'b0, r_acc[W2-1:WIDTH]};
   assign w_add_b = {1'b0, r_opnd} ^ {(WIDTH+1){r_is_div}};
   assign w_sum   = w_add_a + w_add_b + {{WIDTH{1'b0}}, r_is_div};

   always_comb begin
      w_step = r_acc;
      if (r_is_div) begin
         if (w_sum[WIDTH])
            w_step = {w_add_a[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         else
            w_step = {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         if (r_acc[0])
            w_step = {w_sum, r_acc[WIDTH-1:1]};
         else
            w_step = {w_add_a, r_acc[WIDTH-1:1]};
      end
   end

   assign w_prod_fix = r_neg_q ? W2'(neg_w(MD_MAXW'(w_step), W2)) : w_step;
   assign w_quot_fix = r_neg_q ? WIDTH'(neg_w(MD_MAXW'(w_step[WIDTH-1:0]), WIDTH))
                               : w_step[WIDTH-1:0];
   assign w_rem_fix  = r_neg_r ? WIDTH'(neg_w(MD_MAXW'(w_step[W2-1:WIDTH]), WIDTH))
                               : w_step[W2-1:WIDTH];
   assign w_res_hi   = r_is_div ? w_rem_fix  : w_prod_fix[W2-1:WIDTH];
   assign w_res_lo   = r_is_div ? w_quot_fix : w_prod_fix[WIDTH-1:0];

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_state_next = (w_is_div && w_b_zero) ? DONE : RUN;
         RUN:     if (r_cnt == CW'(1)) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (annul) w_state_next = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_opnd     <= '0;
         r_acc      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_ready    <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ready <= 1'b0;
         if (annul) begin
            r_cnt <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_is_div <= w_is_div;
                     r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_neg_r  <= w_signed && a[WIDTH-1];
                     r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                     r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a}
                                          : {{WIDTH{1'b0}}, w_abs_b};
                     r_cnt    <= CW'(WIDTH);
                     // Divide by zero skips RUN and commits the raw dividend.
                     if (w_is_div && w_b_zero) begin
                        r_cnt      <= '0;
                        r_hi       <= a;
                        r_lo       <= '1;
                        r_div_zero <= 1'b1;
                        r_ready    <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  r_acc <= w_step;
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) begin
                     r_hi       <= w_res_hi;
                     r_lo       <= w_res_lo;
                     r_div_zero <= 1'b0;
                     r_ready    <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign stall_req = !annul && ((r_state == RUN) || ((r_state == IDLE) && start));
   assign ready     = r_ready;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_iter;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        annul = 1'b0;
   logic        stall_req;
   logic        ready;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;
   logic        last_dz = 1'b0;

   muldiv_iter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .annul     (annul),
      .stall_req (stall_req),
      .ready     (ready),
      .hi        (hi),
      .lo        (lo),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference results straight from integer arithmetic.
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] mh, output logic [31:0] ml, output logic md);
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      md = 1'b0;
      mh = '0;
      ml = '0;
      if (o == OP_MULTU) begin
         p  = {32'd0, x} * {32'd0, y};
         mh = p[63:32];
         ml = p[31:0];
      end else if (o == OP_MULT) begin
         p  = 64'(sx * sy);
         mh = p[63:32];
         ml = p[31:0];
      end else if (y == 32'd0) begin
         mh = x;
         ml = 32'hFFFF_FFFF;
         md = 1'b1;
      end else if (o == OP_DIVU) begin
         ml = x / y;
         mh = x % y;
      end else begin
         q  = sx / sy;
         r  = sx % sy;
         ml = q[31:0];
         mh = r[31:0];
      end
   endfunction

   task automatic run_op(input string name, input logic [1:0] op_i, input logic [31:0] a_i,
                         input logic [31:0] b_i, input bit hold);
      logic [31:0] eh, el;
      logic        ed;
      int unsigned exp_lat, lat;
      bit          stall_ok;
      model(op_i, a_i, b_i, eh, el, ed);
      exp_lat = (op_i[1] && b_i == 32'd0) ? 1 : 33;
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      #1;
      check({name, ".stall_start"}, 32'(stall_req), 32'd1);
      lat      = 0;
      stall_ok = 1'b1;
      while (lat < 100) begin
         tick();
         lat++;
         if (ready) break;
         if (stall_req !== 1'b1) stall_ok = 1'b0;
         if (hold) begin
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      #1;
      check({name, ".latency"}, 32'(lat), 32'(exp_lat));
      check({name, ".stall_run"}, 32'(stall_ok), 32'd1);
      check({name, ".stall_done"}, 32'(stall_req), 32'd0);
      check({name, ".hi"}, hi, eh);
      check({name, ".lo"}, lo, el);
      check({name, ".div_zero"}, 32'(div_zero), 32'(ed));
      tick();
      check({name, ".ready_1cyc"}, 32'(ready), 32'd0);
      last_hi = eh;
      last_lo = el;
      last_dz = ed;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 20));
         3:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit          saw_ready;
      logic [31:0] ra, rb;
      logic [1:0]  rop;

      #1 rst = 1'b1;
      tick();
      tick();
      check("rst.hi", hi, 32'd0);
      check("rst.lo", lo, 32'd0);
      check("rst.ready", 32'(ready), 32'd0);
      check("rst.div_zero", 32'(div_zero), 32'd0);
      check("rst.stall", 32'(stall_req), 32'd0);
      rst = 1'b0;
      tick();

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max.hi_const", last_hi, 32'hFFFF_FFFE);
      run_op("mult_m3x5", OP_MULT, -32'd3, 32'd5, 1'b0);
      run_op("div_m7d2", OP_DIV, -32'd7, 32'd2, 1'b1);
      run_op("divu_7d2", OP_DIVU, 32'd7, 32'd2, 1'b0);
      run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("div_7_m2", OP_DIV, 32'd7, -32'd2, 1'b0);
      run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("div_zero_s", OP_DIV, -32'd9, 32'd0, 1'b0);

      // Annul during RUN cycle 10.
      start = 1'b1; op = OP_MULTU; a = 32'd1234; b = 32'd5678;
      tick();
      start = 1'b0;
      repeat (9) tick();
      annul = 1'b1;
      #1;
      check("annul_run.stall", 32'(stall_req), 32'd0);
      tick();
      annul = 1'b0;
      saw_ready = 1'b0;
      repeat (40) begin
         if (ready) saw_ready = 1'b1;
         tick();
      end
      check("annul_run.no_ready", 32'(saw_ready), 32'd0);
      check("annul_run.idle", 32'(stall_req), 32'd0);
      check("annul_run.hi", hi, last_hi);
      check("annul_run.lo", lo, last_lo);
      check("annul_run.div_zero", 32'(div_zero), 32'(last_dz));

      // Start and annul together: not accepted.
      start = 1'b1; annul = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd0;
      #1;
      check("annul_start.stall", 32'(stall_req), 32'd0);
      tick();
      start = 1'b0; annul = 1'b0;
      #1;
      check("annul_start.not_run", 32'(stall_req), 32'd0);
      saw_ready = 1'b0;
      repeat (40) begin
         if (ready) saw_ready = 1'b1;
         tick();
      end
      check("annul_start.no_ready", 32'(saw_ready), 32'd0);
      check("annul_start.lo", lo, last_lo);

      run_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, 1'b0);

      // Asynchronous reset mid-RUN.
      start = 1'b1; op = OP_MULTU; a = 32'hDEAD_BEEF; b = 32'h0000_1001;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #3 rst = 1'b1;
      #1;
      check("arst.hi", hi, 32'd0);
      check("arst.lo", lo, 32'd0);
      check("arst.ready", 32'(ready), 32'd0);
      check("arst.div_zero", 32'(div_zero), 32'd0);
      check("arst.stall", 32'(stall_req), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 1'b0);

      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = pick();
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
         run_op($sformatf("rnd%0d", i), rop, ra, rb, bit'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
